// File: rtl/lsu_dmem_arbiter_if.sv
// lsu_dmem_arbiter_if: core/debug request ports and data-memory bank bus of the arbiter.
// Error outputs exist only when LSU_ARB_ALIGN_CHECK_EN is defined.
interface lsu_dmem_arbiter_if #(parameter int DMEM_ADDR = 13);
  logic                 i_c_req, i_c_we, o_c_gnt, o_c_rvalid;
  logic [DMEM_ADDR-1:0] i_c_addr;
  logic [31:0]          i_c_wdata, o_c_rdata;
  logic [2:0]           i_c_funct;
  logic                 i_d_req, i_d_we, o_d_gnt, o_d_rvalid;
  logic [DMEM_ADDR-1:0] i_d_addr;
  logic [31:0]          i_d_wdata, o_d_rdata;
  logic [2:0]           i_d_funct;
  logic                 o_mem_en, o_mem_we;
  logic [DMEM_ADDR-1:0] o_mem_addr;
  logic [31:0]          o_mem_wdata, i_mem_rdata;
  logic [2:0]           o_mem_funct;
`ifdef LSU_ARB_ALIGN_CHECK_EN
  logic                 o_c_err, o_d_err;
  modport slave (
    input  i_c_req, i_c_we, i_c_addr, i_c_wdata, i_c_funct,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_funct, i_mem_rdata,
    output o_c_gnt, o_c_rvalid, o_c_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_funct, o_c_err, o_d_err
  );
  modport master (
    output i_c_req, i_c_we, i_c_addr, i_c_wdata, i_c_funct,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_funct, i_mem_rdata,
    input  o_c_gnt, o_c_rvalid, o_c_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_funct, o_c_err, o_d_err
  );
`else
  modport slave (
    input  i_c_req, i_c_we, i_c_addr, i_c_wdata, i_c_funct,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_funct, i_mem_rdata,
    output o_c_gnt, o_c_rvalid, o_c_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_funct
  );
  modport master (
    output i_c_req, i_c_we, i_c_addr, i_c_wdata, i_c_funct,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_funct, i_mem_rdata,
    input  o_c_gnt, o_c_rvalid, o_c_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_funct
  );
`endif
endinterface

// File: rtl/lsu_dmem_arbiter.sv
// lsu_dmem_arbiter: two-port (core/debug) arbiter onto one data-memory bank, 3-stage pipeline.
// Optional misalignment trapping via LSU_ARB_ALIGN_CHECK_EN.
module lsu_dmem_arbiter #(
  parameter int DMEM_ADDR  = 13,
  parameter int STARVE_MAX = 4
) (
  input logic i_clk,
  input logic i_rst_n,
  lsu_dmem_arbiter_if.slave bus
);
  typedef enum logic {NORMAL, DPRIO} state_e;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 c_gnt, d_gnt, any_gnt, both, sel_we, mis;
  logic [DMEM_ADDR-1:0] sel_addr;
  logic [31:0]          sel_wdata;
  logic [2:0]           sel_funct;
  logic                 mem_en_q, mem_we_q, rd_c_q, rd_d_q, mis_c_q, mis_d_q;
  logic [DMEM_ADDR-1:0] mem_addr_q;
  logic [31:0]          mem_wdata_q, c_rdata_q, d_rdata_q;
  logic [2:0]           mem_funct_q;
  logic                 c_rvalid_q, d_rvalid_q;
`ifdef LSU_ARB_ALIGN_CHECK_EN
  logic                 c_err_q, d_err_q;
  function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
    return (f[1:0] == 2'b01 && a[0]) || (f == 3'd2 && a != 2'b00);
  endfunction
`endif
  // Grants are gated by reset so every output reads 0 while reset is held.
  assign c_gnt = i_rst_n & bus.i_c_req & ~(state_q == DPRIO & bus.i_d_req);
  assign d_gnt = i_rst_n & bus.i_d_req & ~c_gnt;
  assign any_gnt = c_gnt | d_gnt;
  assign both = bus.i_c_req & bus.i_d_req;
  always_comb begin
    sel_we    = d_gnt ? bus.i_d_we    : bus.i_c_we;
    sel_addr  = d_gnt ? bus.i_d_addr  : bus.i_c_addr;
    sel_wdata = d_gnt ? bus.i_d_wdata : bus.i_c_wdata;
    sel_funct = d_gnt ? bus.i_d_funct : bus.i_c_funct;
`ifdef LSU_ARB_ALIGN_CHECK_EN
    mis       = misaligned(sel_funct, sel_addr[1:0]);
`else
    mis       = 1'b0;
`endif
    cnt_d     = (state_q == NORMAL && both) ? cnt_q + 4'd1 : 4'd0;
    state_d   = (state_q == NORMAL && both && cnt_q + 4'd1 == SMAX) ? DPRIO : NORMAL;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= NORMAL;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_funct_q <= '0;
      rd_c_q      <= 1'b0;
      rd_d_q      <= 1'b0;
      mis_c_q     <= 1'b0;
      mis_d_q     <= 1'b0;
      c_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef LSU_ARB_ALIGN_CHECK_EN
      c_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= any_gnt & ~mis;
      mem_we_q    <= any_gnt & ~mis & sel_we & (sel_funct <= 3'd2);
      if (any_gnt) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
        mem_funct_q <= sel_funct;
      end
      rd_c_q      <= c_gnt & ~bus.i_c_we & ~mis;
      rd_d_q      <= d_gnt & ~bus.i_d_we & ~mis;
      mis_c_q     <= c_gnt & mis;
      mis_d_q     <= d_gnt & mis;
      c_rvalid_q  <= rd_c_q | mis_c_q;
      d_rvalid_q  <= rd_d_q | mis_d_q;
      if (rd_c_q | mis_c_q) c_rdata_q <= rd_c_q ? bus.i_mem_rdata : 32'd0;
      if (rd_d_q | mis_d_q) d_rdata_q <= rd_d_q ? bus.i_mem_rdata : 32'd0;
`ifdef LSU_ARB_ALIGN_CHECK_EN
      c_err_q     <= mis_c_q;
      d_err_q     <= mis_d_q;
`endif
    end
  end
  assign bus.o_c_gnt     = c_gnt;
  assign bus.o_d_gnt     = d_gnt;
  assign bus.o_c_rvalid  = c_rvalid_q;
  assign bus.o_d_rvalid  = d_rvalid_q;
  assign bus.o_c_rdata   = c_rdata_q;
  assign bus.o_d_rdata   = d_rdata_q;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_funct = mem_funct_q;
`ifdef LSU_ARB_ALIGN_CHECK_EN
  assign bus.o_c_err     = c_err_q;
  assign bus.o_d_err     = d_err_q;
`endif
endmodule

// File: tb/tb_lsu_dmem_arbiter.sv
// tb_lsu_dmem_arbiter: directed self-checking bench for lsu_dmem_arbiter with a word-wide bank model.
module tb_lsu_dmem_arbiter;
  localparam int AW = 13;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lsu_dmem_arbiter_if #(.DMEM_ADDR(AW)) bus();
  lsu_dmem_arbiter #(.DMEM_ADDR(AW), .STARVE_MAX(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  logic [31:0] bank [0:2047];
  logic        ovr = 1'b0;
  logic [31:0] ovr_val = '0;
  assign bus.i_mem_rdata = ovr ? ovr_val : bank[bus.o_mem_addr[AW-1:2]];
  always @(posedge clk) if (bus.o_mem_en && bus.o_mem_we) bank[bus.o_mem_addr[AW-1:2]] <= bus.o_mem_wdata;
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic drive_c(input logic req, input logic we, input logic [AW-1:0] a, input logic [31:0] wd, input logic [2:0] f);
    bus.i_c_req = req; bus.i_c_we = we; bus.i_c_addr = a; bus.i_c_wdata = wd; bus.i_c_funct = f;
  endtask
  task automatic drive_d(input logic req, input logic we, input logic [AW-1:0] a, input logic [31:0] wd, input logic [2:0] f);
    bus.i_d_req = req; bus.i_d_we = we; bus.i_d_addr = a; bus.i_d_wdata = wd; bus.i_d_funct = f;
  endtask
  task automatic idle();
    bus.i_c_req = 1'b0;
    bus.i_d_req = 1'b0;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive_c(1'b1, 1'b0, '0, '0, '0);
    drive_d(1'b0, 1'b0, '0, '0, '0);
    mid();
    check("rst_c_gnt", bus.o_c_gnt, 0);
    check("rst_mem_en", bus.o_mem_en, 0);
    check("rst_c_rvalid", bus.o_c_rvalid, 0);
    nxt();
    idle();
    rst_n = 1'b1;
    nxt();
    // write word then read it back the next cycle
    drive_c(1'b1, 1'b1, 13'h10, 32'hDEADBEEF, 3'd2);
    mid(); check("raw_wr_gnt", bus.o_c_gnt, 1); check("raw_wr_dgnt", bus.o_d_gnt, 0);
    nxt();
    drive_c(1'b1, 1'b0, 13'h10, '0, 3'd2);
    mid();
    check("raw_mem_en", bus.o_mem_en, 1); check("raw_mem_we", bus.o_mem_we, 1);
    check("raw_mem_addr", bus.o_mem_addr, 32'h10); check("raw_mem_wdata", bus.o_mem_wdata, 32'hDEADBEEF);
    check("raw_mem_funct", bus.o_mem_funct, 2);
    nxt();
    idle();
    mid(); check("raw_rd_en", bus.o_mem_en, 1); check("raw_rd_we", bus.o_mem_we, 0); check("raw_no_rv_yet", bus.o_c_rvalid, 0);
    nxt();
    mid(); check("raw_rvalid", bus.o_c_rvalid, 1); check("raw_rdata", bus.o_c_rdata, 32'hDEADBEEF); check("raw_idle_en", bus.o_mem_en, 0);
    nxt();
    mid(); check("raw_rv_pulse", bus.o_c_rvalid, 0); check("raw_rdata_hold", bus.o_c_rdata, 32'hDEADBEEF);
    check("idle_addr_hold", bus.o_mem_addr, 32'h10);
    nxt();
    // starvation: d wins every fifth contested cycle
    drive_c(1'b1, 1'b0, 13'h40, '0, 3'd2);
    drive_d(1'b1, 1'b0, 13'h44, '0, 3'd2);
    for (int i = 0; i < 10; i++) begin
      mid();
      check($sformatf("starve_c_gnt%0d", i), bus.o_c_gnt, (i == 4 || i == 9) ? 0 : 1);
      check($sformatf("starve_d_gnt%0d", i), bus.o_d_gnt, (i == 4 || i == 9) ? 1 : 0);
      check($sformatf("onehot%0d", i), bus.o_c_gnt & bus.o_d_gnt, 0);
      nxt();
    end
    // d drops its request while in DPRIO: no grant forced, c keeps winning
    for (int i = 0; i < 6; i++) begin
      bus.i_d_req = (i != 4);
      mid();
      check($sformatf("drop_c_gnt%0d", i), bus.o_c_gnt, 1);
      check($sformatf("drop_d_gnt%0d", i), bus.o_d_gnt, 0);
      nxt();
    end
    idle();
    nxt(); nxt(); nxt();
    // debug-port byte read, bank returns a sign-extended value
    drive_d(1'b1, 1'b0, 13'h20, '0, 3'd0);
    mid(); check("d_rd_gnt", bus.o_d_gnt, 1); check("d_rd_cgnt", bus.o_c_gnt, 0);
    nxt();
    idle();
    ovr = 1'b1; ovr_val = 32'hFFFFFF80;
    mid(); check("d_rd_en", bus.o_mem_en, 1); check("d_rd_addr", bus.o_mem_addr, 32'h20); check("d_rd_funct", bus.o_mem_funct, 0);
    nxt();
    mid(); check("d_rvalid", bus.o_d_rvalid, 1); check("d_rdata", bus.o_d_rdata, 32'hFFFFFF80); check("d_rd_c_rvalid", bus.o_c_rvalid, 0);
    nxt();
    ovr = 1'b0;
    mid(); check("d_rv_pulse", bus.o_d_rvalid, 0);
    nxt();
    // write with illegal funct is forwarded without write enable
    drive_c(1'b1, 1'b1, 13'h30, 32'h12345678, 3'd3);
    mid(); check("bad_f_gnt", bus.o_c_gnt, 1);
    nxt();
    idle();
    mid(); check("bad_f_en", bus.o_mem_en, 1); check("bad_f_we", bus.o_mem_we, 0); check("bad_f_funct", bus.o_mem_funct, 3);
    nxt();
    mid(); check("bad_f_c_rv", bus.o_c_rvalid, 0); check("bad_f_d_rv", bus.o_d_rvalid, 0);
    nxt();
    // reset during an in-flight read
    drive_c(1'b1, 1'b0, 13'h10, '0, 3'd2);
    mid(); check("rst_rd_gnt", bus.o_c_gnt, 1);
    nxt();
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", bus.o_mem_en, 0); check("mid_rst_gnt", bus.o_c_gnt, 0);
    check("mid_rst_addr", bus.o_mem_addr, 0); check("mid_rst_rdata", bus.o_c_rdata, 0);
    nxt();
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check($sformatf("post_rst_rv%0d", i), bus.o_c_rvalid, 0);
      check($sformatf("post_rst_en%0d", i), bus.o_mem_en, 0);
      nxt();
    end
`ifdef LSU_ARB_ALIGN_CHECK_EN
    drive_c(1'b1, 1'b0, 13'h10, '0, 3'd2);
    nxt();
    drive_c(1'b1, 1'b0, 13'h13, '0, 3'd2);
    mid(); check("mis_gnt", bus.o_c_gnt, 1);
    nxt();
    idle();
    mid(); check("mis_en", bus.o_mem_en, 0); check("ok_rvalid", bus.o_c_rvalid, 1);
    check("ok_rdata", bus.o_c_rdata, 32'hDEADBEEF); check("ok_err", bus.o_c_err, 0);
    nxt();
    mid(); check("mis_rvalid", bus.o_c_rvalid, 1); check("mis_err", bus.o_c_err, 1); check("mis_rdata", bus.o_c_rdata, 0);
    nxt();
    mid(); check("mis_err_pulse", bus.o_c_err, 0);
    nxt();
    drive_d(1'b1, 1'b1, 13'h21, 32'hAA, 3'd1);
    nxt();
    idle();
    mid(); check("mis_wr_en", bus.o_mem_en, 0); check("mis_wr_we", bus.o_mem_we, 0);
    nxt();
    mid(); check("mis_wr_rvalid", bus.o_d_rvalid, 1); check("mis_wr_err", bus.o_d_err, 1);
    nxt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_dmem_arbiter.md
Name: lsu_dmem_arbiter

Overview:
- Shares the single byte-addressed data-memory bank between two requesters: the pipeline MEM stage (core port, "c") and a debug/DMA loader (port "d").
- Arbitrates requests, registers the winning access onto the bank's enable/write/address/data/funct inputs, and captures the bank's combinational read data.
- Returns read data to the winner with a fixed latency.
- Sits between the MEM stage / debug loader and the data-memory bank.

Parameters:
- DMEM_ADDR, 13, byte-address width of the bank.
- STARVE_MAX, 4, consecutive lost arbitration cycles after which port d wins once. Legal range 1..15.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_c_req  in  1  core request valid.
- i_c_we  in  1  core write (1) / read (0).
- i_c_addr  in  DMEM_ADDR  core byte address.
- i_c_wdata  in  32  core store data.
- i_c_funct  in  3  core load/store kind (funct3 encoding).
- o_c_gnt  out  1  core request accepted this cycle.
- o_c_rvalid  out  1  core read data valid (1-cycle pulse).
- o_c_rdata  out  32  core read data.
- i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_funct  in  1/1/DMEM_ADDR/32/3  debug port, same meaning as the core port.
- o_d_gnt, o_d_rvalid, o_d_rdata  out  1/1/32  debug port, same meaning as the core port.
- o_mem_en  out  1  bank enable.
- o_mem_we  out  1  bank write enable.
- o_mem_addr  out  DMEM_ADDR  bank address.
- o_mem_wdata  out  32  bank write data.
- o_mem_funct  out  3  bank funct code.
- i_mem_rdata  in  32  bank combinational read data.

Behaviour:
- Reset: all outputs 0, starvation counter 0, in-flight tags cleared. Reset asserted mid-access drops the access: no rvalid, no write after reset releases.
- Pipeline: the bank has combinational read and synchronous write. The arbiter therefore has three stages:
  - Stage A, cycle N: arbitration. o_*_gnt is combinational from the requests and the arbiter state.
  - Stage B, cycle N+1: the registered access is presented on o_mem_*, with o_mem_en=1. A write commits at the end of N+1.
  - Stage C, cycle N+2: for reads only, i_mem_rdata sampled at the end of N+1 appears on o_x_rdata with o_x_rvalid=1 for exactly one cycle.
  - Writes produce no rvalid.
  - Throughput is one access per cycle, fully pipelined, with no busy state.
- Handshake: a request is consumed in a cycle where req=1 and gnt=1. A requester holds req and its payload stable until granted. At most one gnt is high per cycle.
- Arbitration, held in a two-state FSM:
  - NORMAL: core has fixed priority. If both ports request, c wins and the starvation counter increments. If d is granted, or d does not request, the counter clears to 0.
  - When the counter reaches STARVE_MAX while d is still requesting, the FSM moves to DPRIO.
  - DPRIO: d wins the next arbitration unconditionally, the counter clears, and the FSM returns to NORMAL. If d drops its request while in DPRIO, the FSM returns to NORMAL with no grant forced.
- No request: o_mem_en=0 and o_mem_we=0 in the following cycle. o_mem_addr, o_mem_wdata and o_mem_funct hold their last values.
- Read data:
  - o_x_rdata updates only with o_x_rvalid and holds otherwise.
  - Extension is done by the bank; the arbiter passes the data through unmodified.
- Illegal funct: a write with funct>2 is forwarded with o_mem_we forced to 0; no write occurs and no rvalid is produced. Reads with an unsupported funct pass through, and the bank returns 0.
- Read-after-write: a read granted in the cycle after a write to the same address sees the new data, because the write commits before the read's stage B.

Optional Feature:
- Macro: LSU_ARB_ALIGN_CHECK_EN.
- Enabled:
  - A halfword access (funct 1/5) with addr[0]=1, or a word access (funct 2) with addr[1:0]≠0, is granted normally but not forwarded: o_mem_en=0 in stage B.
  - Stage C pulses o_x_rvalid with o_x_rdata=0 and o_x_err=1 for one cycle, for both reads and writes.
  - Adds outputs o_c_err and o_d_err (1 bit each, reset 0).
- Disabled: o_x_err ports are absent, and misaligned accesses are forwarded unchanged.

Test Plan:
- Core write word 0xDEADBEEF at addr 0x10 in cycle 0, core read word at 0x10 in cycle 1 -> o_mem_we=1 in cycle 1; o_c_rvalid=1 with o_c_rdata=0xDEADBEEF in cycle 3.
- Core and d both request continuously with STARVE_MAX=4 -> grant order c,c,c,c,d,c,c,c,c,d; never two gnts in one cycle.
- d-only read of byte funct 0 at 0x20, bank returning 0xFFFFFF80 -> o_d_rvalid at N+2 with 0xFFFFFF80; o_c_rvalid stays 0.
- Write with funct=3 -> granted, o_mem_en=1, o_mem_we=0, no rvalid on either port.
- Read granted, then i_rst_n low in cycle N+1 -> all outputs 0 immediately; no rvalid after release.
- LSU_ARB_ALIGN_CHECK_EN: word read at 0x13 -> o_mem_en=0; at N+2 o_c_rvalid=1, o_c_err=1, o_c_rdata=0.
